// File: rtl/ama_riscv_perf_pkg.sv
// Shared types and constants for the performance-counter unit.
package ama_riscv_perf_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    FROZEN  = 2'd2
  } perf_state_t;

  // Event channel assignment as wired beside the core top.
  localparam int EVT_CYCLE   = 0;
  localparam int EVT_RETIRE  = 1;
  localparam int EVT_BUBBLE  = 2;
  localparam int EVT_IC_HIT  = 3;
  localparam int EVT_IC_MISS = 4;
  localparam int EVT_DC_HIT  = 5;
  localparam int EVT_DC_MISS = 6;
  localparam int EVT_BP_MISS = 7;

  localparam int PERF_RD_LAT = 1;

endpackage

// File: rtl/ama_riscv_perf_counter.sv
// One event counter: wrapping increment, synchronous clear, sticky overflow.
module ama_riscv_perf_counter
  import ama_riscv_perf_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  // Clear wins over a coincident increment, so that event is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
      if (&cnt_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/ama_riscv_perf_cnt_unit.sv
// Performance-counter unit: run/stop/freeze FSM, NUM_EVT event counters,
// and a 32-bit read port with a hi-word shadow for atomic 64-bit reads.
module ama_riscv_perf_cnt_unit
  import ama_riscv_perf_pkg::*;
#(
  parameter  int NUM_EVT = 8,
  parameter  int CNT_W   = 64,
  localparam int SEL_W   = $clog2(NUM_EVT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               clr_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               freeze_i,
  input  logic [NUM_EVT-1:0] en_mask_i,
  input  logic               rd_req_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  input  logic               rd_hi_i,
  output logic               rd_valid_o,
  output logic [31:0]        rd_data_o,
  output logic [NUM_EVT-1:0] ovf_o,
  output logic [1:0]         state_o
);

  localparam int NUM_SEL = 1 << SEL_W;

  // Handshake: a read has no backpressure. rd_req_i sampled high at edge N
  // yields rd_valid_o=1 with rd_data_o for exactly cycle N+1; rd_data_o
  // holds its last value whenever rd_valid_o is low.

  perf_state_t        state_q;
  perf_state_t        state_d;
  logic               running;
  logic [NUM_EVT-1:0] inc;
  logic [CNT_W-1:0]   cnt [NUM_EVT];

  logic [31:0]        lo_word [NUM_SEL];
  logic [31:0]        hi_word [NUM_SEL];
  logic [NUM_SEL-1:0] sel_ok;
  logic [31:0]        sel_lo;
  logic [31:0]        sel_hi;
  logic               sel_in;

  logic [31:0]        shadow_q;
  logic               rd_valid_q;
  logic [31:0]        rd_data_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority when inputs coincide: clr > freeze > stop > start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: begin
        if (!clr_i && !freeze_i && !stop_i && start_i) begin
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        if (clr_i) begin
          state_d = RUNNING;
        end else if (freeze_i) begin
          state_d = FROZEN;
        end else if (stop_i) begin
          state_d = STOPPED;
        end
      end
      FROZEN: begin
        if (clr_i) begin
          state_d = STOPPED;
        end
      end
      default: state_d = STOPPED;
    endcase
  end

  assign running = (state_q == RUNNING);
  assign state_o = state_q;

  // ----------------------------------------------------------- counters
  for (genvar k = 0; k < NUM_EVT; k++) begin : gen_ch
    if (k == EVT_CYCLE) begin : gen_cycle
      // The cycle channel counts every running cycle; its event bit is a don't-care.
      assign inc[k] = running & en_mask_i[k] & (evt_i[k] | 1'b1);
    end else begin : gen_event
      assign inc[k] = running & en_mask_i[k] & evt_i[k];
    end

    ama_riscv_perf_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr_i),
      .inc (inc[k]),
      .cnt (cnt[k]),
      .ovf (ovf_o[k])
    );
  end

  // ----------------------------------------------------------- read mux
  // Pad the select space to a power of two; unused slots read as zero.
  for (genvar g = 0; g < NUM_SEL; g++) begin : gen_sel
    if (g < NUM_EVT) begin : gen_in
      assign lo_word[g] = cnt[g][31:0];
      assign hi_word[g] = 32'(cnt[g] >> 32);
      assign sel_ok[g]  = 1'b1;
    end else begin : gen_out
      assign lo_word[g] = '0;
      assign hi_word[g] = '0;
      assign sel_ok[g]  = 1'b0;
    end
  end

  assign sel_lo = lo_word[rd_sel_i];
  assign sel_hi = hi_word[rd_sel_i];
  assign sel_in = sel_ok[rd_sel_i];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      shadow_q   <= '0;
    end else begin
      rd_valid_q <= rd_req_i;
      if (rd_req_i) begin
        if (rd_hi_i) begin
          rd_data_q <= shadow_q;
        end else if (sel_in) begin
          rd_data_q <= sel_lo;
        end else begin
          rd_data_q <= '0;
        end
      end
      // A lo-word read captures the matching hi word; clear beats that load.
      if (clr_i) begin
        shadow_q <= '0;
      end else if (rd_req_i && !rd_hi_i && sel_in) begin
        shadow_q <= sel_hi;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_ama_riscv_perf_cnt_unit.sv
// Directed and randomized bench for ama_riscv_perf_cnt_unit against a
// cycle-level reference model of the counter rules.
module tb_ama_riscv_perf_cnt_unit;

  localparam int NUM_EVT = 6;
  localparam int CNT_W   = 64;
  localparam int SEL_W   = $clog2(NUM_EVT);

  // ------------------------------------------------ clock / reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_EVT-1:0] evt;
  logic               clr;
  logic               start;
  logic               stop;
  logic               freeze;
  logic [NUM_EVT-1:0] en_mask;
  logic               rd_req;
  logic [SEL_W-1:0]   rd_sel;
  logic               rd_hi;
  logic               rd_valid;
  logic [31:0]        rd_data;
  logic [NUM_EVT-1:0] ovf;
  logic [1:0]         state;

  ama_riscv_perf_cnt_unit #(
    .NUM_EVT (NUM_EVT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .evt_i      (evt),
    .clr_i      (clr),
    .start_i    (start),
    .stop_i     (stop),
    .freeze_i   (freeze),
    .en_mask_i  (en_mask),
    .rd_req_i   (rd_req),
    .rd_sel_i   (rd_sel),
    .rd_hi_i    (rd_hi),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .ovf_o      (ovf),
    .state_o    (state)
  );

  // ---------------------------------------------------- reference model
  logic [63:0]        m_cnt [NUM_EVT];
  logic [NUM_EVT-1:0] m_ovf;
  int                 m_state;   // 0 stopped, 1 running, 2 frozen
  logic [31:0]        m_shadow;
  logic               m_rd_valid;
  logic [31:0]        m_rd_data;
  logic [31:0]        exp_q[$];

  int errors = 0;
  int checks = 0;
  logic [63:0] pre_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs presented now, then
  // let the DUT take the same edge and compare outputs 1ns after it.
  task automatic tick();
    logic running;
    if (!rst) begin
      for (int k = 0; k < NUM_EVT; k++) m_cnt[k] = '0;
      m_ovf      = '0;
      m_shadow   = '0;
      m_state    = 0;
      m_rd_valid = 1'b0;
      m_rd_data  = '0;
      exp_q.delete();
    end else begin
      running    = (m_state == 1);
      m_rd_valid = rd_req;
      if (rd_req) begin
        if (rd_hi) begin
          m_rd_data = m_shadow;
        end else if (int'(rd_sel) < NUM_EVT) begin
          m_rd_data = m_cnt[rd_sel][31:0];
          m_shadow  = m_cnt[rd_sel][63:32];
        end else begin
          m_rd_data = '0;
        end
        exp_q.push_back(m_rd_data);
      end
      if (clr) m_shadow = '0;
      for (int k = 0; k < NUM_EVT; k++) begin
        if (clr) begin
          m_cnt[k] = '0;
          m_ovf[k] = 1'b0;
        end else if (running && en_mask[k] && (k == 0 || evt[k])) begin
          if (m_cnt[k] == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf[k] = 1'b1;
          m_cnt[k] = m_cnt[k] + 64'd1;
        end
      end
      if (clr) begin
        if (m_state == 2) m_state = 0;
      end else if (m_state == 1) begin
        if (freeze) m_state = 2;
        else if (stop) m_state = 0;
      end else if (m_state == 0) begin
        if (start && !freeze && !stop) m_state = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("state", 64'(state), 64'(m_state));
    chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    if (m_rd_valid && exp_q.size() > 0) chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
    else chk("rd_hold", 64'(rd_data), 64'(m_rd_data));
    chk("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  // ------------------------------------------------------ driver tasks
  task automatic rd(input logic [SEL_W-1:0] sel, input logic hi, input logic [31:0] exp,
                    input string tag);
    rd_req = 1'b1;
    rd_sel = sel;
    rd_hi  = hi;
    tick();
    rd_req = 1'b0;
    rd_hi  = 1'b0;
    chk(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Jump a counter to pre_val between clock edges (no port can reach 2^32).
  task preload(input int ch);
    case (ch)
      0: force dut.gen_ch[0].u_cnt.cnt_q = pre_val;
      1: force dut.gen_ch[1].u_cnt.cnt_q = pre_val;
      2: force dut.gen_ch[2].u_cnt.cnt_q = pre_val;
      3: force dut.gen_ch[3].u_cnt.cnt_q = pre_val;
      4: force dut.gen_ch[4].u_cnt.cnt_q = pre_val;
      default: force dut.gen_ch[5].u_cnt.cnt_q = pre_val;
    endcase
    #1;
    case (ch)
      0: release dut.gen_ch[0].u_cnt.cnt_q;
      1: release dut.gen_ch[1].u_cnt.cnt_q;
      2: release dut.gen_ch[2].u_cnt.cnt_q;
      3: release dut.gen_ch[3].u_cnt.cnt_q;
      4: release dut.gen_ch[4].u_cnt.cnt_q;
      default: release dut.gen_ch[5].u_cnt.cnt_q;
    endcase
    m_cnt[ch] = pre_val;
  endtask

  // -------------------------------------------------------- stimulus
  initial begin
    rst     = 1'b0;
    evt     = '0;
    clr     = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    freeze  = 1'b0;
    en_mask = '1;
    rd_req  = 1'b0;
    rd_sel  = '0;
    rd_hi   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b1;

    // Run: 10 running cycles plus the stop cycle on the cycle channel
    pulse_start();
    chk("run_state", 64'(state), 64'd1);
    repeat (10) tick();
    pulse_stop();
    chk("stop_state", 64'(state), 64'd0);
    rd(0, 1'b0, 32'd11, "ch0_lo");
    rd(0, 1'b1, 32'd0, "ch0_hi");

    // Event gating: stopped pulses ignored, masked channel stays zero
    pulse_clr();
    repeat (3) begin
      evt = 6'b000010;
      tick();
      evt = '0;
      tick();
    end
    en_mask[3] = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      evt[1] = 1'b1;
      if (i < 4) evt[3] = 1'b1;
      tick();
      evt = '0;
      tick();
    end
    pulse_stop();
    en_mask = '1;
    rd(1, 1'b0, 32'd5, "ch1_evt");
    rd(3, 1'b0, 32'd0, "ch3_masked");

    // Wrap from all-ones with sticky overflow
    pre_val = 64'hFFFF_FFFF_FFFF_FFFF;
    preload(2);
    pulse_start();
    evt[2] = 1'b1;
    tick();
    evt = '0;
    chk("wrap_ovf", 64'(ovf[2]), 64'd1);
    pulse_stop();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("ovf_sticky", 64'(ovf[2]), 64'd1);
    end
    rd(2, 1'b0, 32'd0, "wrap_lo");
    rd(2, 1'b1, 32'd0, "wrap_hi");
    pulse_clr();
    chk("ovf_clr", 64'(ovf[2]), 64'd0);

    // Atomic lo/hi read while the live hi word moves on
    pre_val = 64'h0000_0000_FFFF_FFFE;
    preload(0);
    pulse_start();
    rd(0, 1'b0, 32'hFFFF_FFFE, "atom_lo");
    tick();
    tick();
    rd(3, 1'b1, 32'd0, "atom_hi");
    rd(0, 1'b0, 32'd2, "live_lo");
    rd(0, 1'b1, 32'd1, "live_hi");
    pulse_stop();

    // Freeze beats stop; start ignored while frozen; clear returns to stopped
    pulse_start();
    repeat (3) tick();
    freeze = 1'b1;
    stop   = 1'b1;
    tick();
    freeze = 1'b0;
    stop   = 1'b0;
    chk("freeze_state", 64'(state), 64'd2);
    pulse_start();
    chk("frozen_start", 64'(state), 64'd2);
    pulse_clr();
    chk("clr_state", 64'(state), 64'd0);
    for (int ch = 0; ch < NUM_EVT; ch++) rd(SEL_W'(ch), 1'b0, 32'd0, "clr_zero");

    // Clear coincident with a read and an event
    pulse_start();
    repeat (7) begin
      evt[1] = 1'b1;
      tick();
      evt = '0;
    end
    clr    = 1'b1;
    evt[1] = 1'b1;
    rd(1, 1'b0, 32'd7, "clr_rd");
    clr = 1'b0;
    evt = '0;
    chk("clr_keeps_run", 64'(state), 64'd1);
    pulse_stop();
    rd(1, 1'b0, 32'd0, "ch1_after_clr");
    pre_val = 64'h0000_00AB_0000_0001;
    preload(4);
    rd(4, 1'b0, 32'd1, "ld_lo");
    rd(SEL_W'(NUM_EVT), 1'b0, 32'd0, "oor_data");
    chk("oor_valid", 64'(rd_valid), 64'd1);
    rd(0, 1'b1, 32'h0000_00AB, "oor_shadow");

    // Randomized traffic with counters parked near their word boundaries
    pre_val = 64'h0000_0000_FFFF_FF00;
    preload(0);
    pre_val = 64'h0000_0000_FFFF_FFF0;
    preload(1);
    pre_val = 64'hFFFF_FFFF_FFFF_FFF8;
    preload(2);
    for (int i = 0; i < 800; i++) begin
      clr     = ($urandom_range(0, 99) == 0);
      start   = ($urandom_range(0, 4) == 0);
      stop    = ($urandom_range(0, 19) == 0);
      freeze  = ($urandom_range(0, 59) == 0);
      evt     = NUM_EVT'($urandom);
      en_mask = ($urandom_range(0, 3) == 0) ? NUM_EVT'($urandom) : '1;
      rd_req  = ($urandom_range(0, 1) == 1);
      rd_sel  = SEL_W'($urandom_range(0, 7));
      rd_hi   = ($urandom_range(0, 1) == 1);
      rst     = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst    = 1'b1;
    clr    = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    freeze = 1'b0;
    evt    = '0;
    rd_req = 1'b0;
    tick();

    // -------------------------------------------------------- report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ama_riscv_perf_cnt_unit.md
Name: ama_riscv_perf_cnt_unit

Overview:
- Synthesizable hardware performance-counter unit for the core. It generalises the bench-side perf statistics (retire/bubble counting, cache and branch-predictor hit/miss) into NUM_EVT parametrised event channels.
- Each channel is a CNT_W-bit counter with a sticky overflow flag, readable over a 32-bit word-select read port.
- It sits beside the core top, fed by writeback/cache/BP event pulses. Control comes from mmio_reset_cnt and tohost-derived freeze.
- A global run FSM gates counting, and a lo/hi snapshot gives atomic 64-bit reads.

Parameters:
- NUM_EVT, 8, number of event channels (2..32); channel 0 is always the cycle counter.
- CNT_W, 64, counter width in bits (33..64); hi word is zero-extended above CNT_W-32.
- SEL_W, $clog2(NUM_EVT), channel-select width (derived, not overridden).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- evt_i  in  NUM_EVT  one-cycle event pulses; bit 0 ignored (cycle channel self-increments)
- clr_i  in  1  counter clear (driven from mmio_reset_cnt)
- start_i  in  1  enter RUNNING
- stop_i  in  1  enter STOPPED
- freeze_i  in  1  enter FROZEN (driven from tohost[0])
- en_mask_i  in  NUM_EVT  per-channel count enable
- rd_req_i  in  1  read request
- rd_sel_i  in  SEL_W  channel select
- rd_hi_i  in  1  0 = low word, 1 = high word
- rd_valid_o  out  1  read data valid
- rd_data_o  out  32  read data
- ovf_o  out  NUM_EVT  sticky per-channel overflow
- state_o  out  2  FSM state: 0 STOPPED, 1 RUNNING, 2 FROZEN

Behaviour:
- Reset (rst==0 at posedge): all counters 0, ovf_o 0, shadow 0, state STOPPED, rd_valid_o 0, rd_data_o 0. Reset mid-read drops the pending response.
- FSM transitions:
  - STOPPED -> RUNNING on start_i.
  - RUNNING -> STOPPED on stop_i.
  - RUNNING -> FROZEN on freeze_i.
  - FROZEN -> STOPPED only on clr_i.
  - start_i in FROZEN is ignored.
  - Priority when inputs coincide: clr_i > freeze_i > stop_i > start_i.
- Counting: channel k increments by 1 when state==RUNNING, en_mask_i[k]==1, and (k==0 or evt_i[k]==1). The new value is visible the next cycle.
- Events in the cycle of the start_i edge are not counted (the state is still STOPPED). Events in the cycle of the stop_i/freeze_i edge are counted (the state is still RUNNING).
- Wrap: when a counter at all-ones increments, it becomes 0 and its ovf_o[k] is set in the same edge. ovf_o is sticky until clr_i or reset.
- clr_i: all counters, ovf_o and shadow go to 0 next cycle. An event coincident with clr_i is dropped. The state goes to STOPPED only if it was FROZEN; otherwise the state is unchanged.
- Read port timing: 1-cycle latency. rd_req_i sampled at edge N gives rd_valid_o=1 and rd_data_o during cycle N+1. Back-to-back requests are supported every cycle. rd_valid_o is 0 when there is no request, and rd_data_o holds its last value.
- Read data: the returned value is the counter before any increment at the sampling edge.
- Low-word read of channel k: returns cnt[k][31:0] and loads shadow <= cnt[k][CNT_W-1:32] (zero-extended).
- High-word read: returns shadow regardless of rd_sel_i, giving an atomic 64-bit read as lo then hi.
- Out-of-range select: rd_sel_i >= NUM_EVT returns 0 with rd_valid_o=1, and the shadow is unchanged.
- Read vs clear: a read coincident with clr_i returns the pre-clear value. A shadow load coincident with clr_i loses to clear (shadow = 0).
- Reads are allowed in every state.

Decomposition:
- Package ama_riscv_perf_pkg holds:
  - perf_state_t enum (STOPPED/RUNNING/FROZEN);
  - event index constants: EVT_CYCLE=0, EVT_RETIRE=1, EVT_BUBBLE=2, EVT_IC_HIT=3, EVT_IC_MISS=4, EVT_DC_HIT=5, EVT_DC_MISS=6, EVT_BP_MISS=7;
  - PERF_RD_LAT=1.
- Sub-module ama_riscv_perf_counter: one CNT_W counter with inc, clr, ovf; generate-instantiated NUM_EVT times.
- The top level owns the FSM, shadow and read mux.

Test Plan:
- Reset/run: reset, start_i for 1 cycle, 10 RUNNING cycles, stop_i.
  - Expect ch0 lo read = 11 (10 cycles plus the stop cycle), hi = 0, state_o 0→1→0.
- Event gating: evt_i[1] pulsed 5x while RUNNING, 3x while STOPPED; en_mask_i[3]=0 with evt_i[3] pulsed 4x.
  - Expect ch1 = 5, ch3 = 0.
- Wrap: force ch2 to 0xFFFF_FFFF_FFFF_FFFF (CNT_W=64), then one evt_i[2].
  - Expect ch2 = 0, ovf_o[2]=1 held for 20 cycles; then clr_i → ovf_o[2]=0.
- Atomic read: ch0 = 0x0000_0000_FFFF_FFFE while RUNNING; read lo, then hi 3 cycles later.
  - Expect lo=0xFFFFFFFE and hi=0x00000000 (shadow), even though live hi has become 1.
- Freeze priority: freeze_i and stop_i asserted in the same cycle.
  - Expect state FROZEN; start_i ignored; clr_i → STOPPED with all counters 0.
- Clear/read collision: clr_i with rd_req_i on ch1 (value 7) plus evt_i[1].
  - Expect rd_data_o=7 next cycle, ch1 = 0 after, then rd_sel_i=NUM_EVT returns 0 with rd_valid_o=1.
